// File: rtl/fp_add_scheduler_pkg.sv
// Shared constants for the fp_add_scheduler block: FSM state codes, float width, watchdog default.
package fp_add_scheduler_pkg;

  localparam int FP_W            = 8;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_RESP  = 3'd3;
  localparam state_t ST_ABORT = 3'd4;

endpackage

// File: rtl/fp_add_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector; the first set req bit at or after i_ptr wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_winner
);

  logic [PW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester overwrites earlier picks.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(i_ptr) + i) % NREQ);
      if (i_req[w_idx]) begin
        o_winner        = '0;
        o_winner[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Arbitrates NREQ requesters onto one shared multi-cycle adder, one transaction at a time.
// Optional watchdog with err output: define FP_ADD_SCHED_WATCHDOG_EN.
module fp_add_scheduler
  import fp_add_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [FP_W*NREQ-1:0] op_a,
  input  logic [FP_W*NREQ-1:0] op_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [FP_W-1:0]      result,
  output logic                 busy,
  output logic [FP_W-1:0]      adder_a,
  output logic [FP_W-1:0]      adder_b,
  output logic                 adder_start,
  input  logic [FP_W-1:0]      adder_sum,
  input  logic                 adder_valid,
`ifdef FP_ADD_SCHED_WATCHDOG_EN
  output logic                 err,
`endif
  output logic [2:0]           dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [FP_W-1:0] r_result;
  logic [FP_W-1:0] r_adder_a;
  logic [FP_W-1:0] r_adder_b;
  logic            r_start;
  logic            r_valid_q;
  logic [PW-1:0]   r_ptr;

  logic [NREQ-1:0] w_winner;
  logic [FP_W-1:0] w_sel_a;
  logic [FP_W-1:0] w_sel_b;
  logic [PW-1:0]   w_next_ptr;
  logic            w_complete;

`ifdef FP_ADD_SCHED_WATCHDOG_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] r_wcnt;
  logic           r_err;
  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner)
  );

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_next_ptr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner[i]) begin
        w_sel_a    = op_a[i*FP_W +: FP_W];
        w_sel_b    = op_b[i*FP_W +: FP_W];
        w_next_ptr = PW'((i + 1) % NREQ);
      end
    end
  end

  // A valid level still high from the previous operation is not a completion.
  assign w_complete = adder_valid & ~r_valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_result  <= '0;
      r_adder_a <= '0;
      r_adder_b <= '0;
      r_start   <= 1'b0;
      r_valid_q <= 1'b0;
      r_ptr     <= '0;
`ifdef FP_ADD_SCHED_WATCHDOG_EN
      r_wcnt    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_valid_q <= adder_valid;
      r_start   <= 1'b0;
      r_done    <= '0;
`ifdef FP_ADD_SCHED_WATCHDOG_EN
      r_err     <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state   <= ST_ISSUE;
            r_gnt     <= w_winner;
            r_adder_a <= w_sel_a;
            r_adder_b <= w_sel_b;
            r_start   <= 1'b1;
            r_ptr     <= w_next_ptr;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
`ifdef FP_ADD_SCHED_WATCHDOG_EN
          r_wcnt  <= '0;
`endif
        end
        ST_WAIT: begin
          if (w_complete) begin
            r_result <= adder_sum;
            r_done   <= r_gnt;
            r_state  <= ST_RESP;
          end
`ifdef FP_ADD_SCHED_WATCHDOG_EN
          else if (r_wcnt == WCW'(TIMEOUT - 1)) begin
            r_result <= '0;
            r_done   <= r_gnt;
            r_err    <= 1'b1;
            r_state  <= ST_ABORT;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
`ifdef FP_ADD_SCHED_WATCHDOG_EN
        ST_ABORT: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign result      = r_result;
  assign busy        = (r_state != ST_IDLE);
  assign adder_a     = r_adder_a;
  assign adder_b     = r_adder_b;
  assign adder_start = r_start;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: vector table of single transactions plus hand-written corner sequences.
module tb_fp_add_scheduler;
  import fp_add_scheduler_pkg::*;

  localparam int NREQ = 4;
`ifdef FP_ADD_SCHED_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        busy;
  logic [7:0]  adder_a;
  logic [7:0]  adder_b;
  logic        adder_start;
  logic [7:0]  adder_sum = '0;
  logic        adder_valid = 1'b0;
  logic [2:0]  dbg_state;
`ifdef FP_ADD_SCHED_WATCHDOG_EN
  logic        err;
`endif

  fp_add_scheduler #(.NREQ(NREQ), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .busy        (busy),
    .adder_a     (adder_a),
    .adder_b     (adder_b),
    .adder_start (adder_start),
    .adder_sum   (adder_sum),
    .adder_valid (adder_valid),
`ifdef FP_ADD_SCHED_WATCHDOG_EN
    .err         (err),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;

  logic [11:0] exp_q[$];
  logic [15:0] op_q[$];
  logic [7:0]  ret_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- adder model ----------------
  int         m_cnt = 0;
  int         m_lat = 5;
  int         m_drop_at = -1;
  bit         m_keep = 1'b0;
  bit         m_never = 1'b0;
  logic [7:0] m_ret = '0;

  always @(negedge clk) begin
    if (reset && adder_start) begin
      m_cnt = m_never ? 0 : m_lat;
      m_ret = (ret_q.size() > 0) ? ret_q.pop_front() : 8'h00;
      if (!m_keep) adder_valid = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == m_drop_at) adder_valid = 1'b0;
      if (m_cnt == 0) begin
        adder_valid = 1'b1;
        adder_sum   = m_ret;
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [11:0] mon_e;
  logic [15:0] mon_o;
  logic [3:0]  prev_gnt = '0;

  always @(negedge clk) begin
    if (reset && done != 4'd0) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'({done, result}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_vector", 32'(done), 32'(mon_e[11:8]));
        check("result", 32'(result), 32'(mon_e[7:0]));
      end
    end
    if (reset && adder_start) begin
      if (op_q.size() == 0) begin
        check("start_unexpected", 32'(adder_start), 32'd0);
      end else begin
        mon_o = op_q.pop_front();
        check("adder_a", 32'(adder_a), 32'(mon_o[15:8]));
        check("adder_b", 32'(adder_b), 32'(mon_o[7:0]));
      end
    end
    if (gnt != 4'd0 && gnt !== prev_gnt) check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    prev_gnt = gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_outputs", 32'({gnt, done, result, adder_a, adder_b, adder_start, busy}), 32'd0);
`ifdef FP_ADD_SCHED_WATCHDOG_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done != 4'd0) begin
        cycles = k;
        return;
      end
    end
  endtask

  task automatic drive_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ret, input bit expect_done);
    op_a = $urandom;
    op_b = $urandom;
    op_a[idx*8 +: 8] = a;
    op_b[idx*8 +: 8] = b;
    req = 4'(1 << idx);
    ret_q.push_back(ret);
    op_q.push_back({a, b});
    if (expect_done) exp_q.push_back({4'(1 << idx), ret});
  endtask

  task automatic issue_check(input int idx);
    @(posedge clk);
    #1;
    check("start_t1", 32'(adder_start), 32'd1);
    check("gnt", 32'(gnt), 32'(1 << idx));
    check("busy", 32'(busy), 32'd1);
  endtask

  task automatic run_single(input int idx, input logic [7:0] a, input logic [7:0] b,
                            input int lat, input logic [7:0] ret);
    int k;
    @(negedge clk);
    m_lat = lat; m_keep = 1'b0; m_never = 1'b0; m_drop_at = -1;
    drive_req(idx, a, b, ret, 1'b1);
    issue_check(idx);
    req = '0;
    wait_done(k);
    check("latency", 32'(k), 32'(lat + 1));
    @(posedge clk);
    #1;
    check("idle_after", 32'({busy, gnt, done}), 32'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int k;
    int order[5];
    tbl[0] = '{1, 8'h35, 8'h22, 5, 8'h47};
    tbl[1] = '{0, 8'hFF, 8'h01, 1, 8'h00};
    tbl[2] = '{3, 8'h80, 8'h80, 2, 8'hC1};
    tbl[3] = '{2, 8'h12, 8'h34, 7, 8'h46};
    tbl[4] = '{1, 8'h00, 8'h00, 4, 8'hFF};
    for (int i = 5; i < 7; i++) begin
      tbl[i].idx = $urandom_range(0, 3);
      tbl[i].a   = 8'($urandom_range(0, 255));
      tbl[i].b   = 8'($urandom_range(0, 255));
      tbl[i].lat = $urandom_range(1, 8);
      tbl[i].ret = 8'($urandom_range(0, 255));
    end

    do_reset();
    for (int i = 0; i < 7; i++) run_single(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].ret);

    // All four requesting from reset: grants must rotate 0,1,2,3,0.
    do_reset();
    order = '{0, 1, 2, 3, 0};
    @(negedge clk);
    m_lat = 3; m_keep = 1'b0; m_never = 1'b0; m_drop_at = -1;
    op_a = $urandom;
    op_b = $urandom;
    req  = 4'hF;
    for (int j = 0; j < 5; j++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      ret_q.push_back(r);
      op_q.push_back({op_a[order[j]*8 +: 8], op_b[order[j]*8 +: 8]});
      exp_q.push_back({4'(1 << order[j]), r});
    end
    for (int j = 0; j < 5; j++) begin
      wait_done(k);
      check("rr_order", 32'(done), 32'(1 << order[j]));
      if (j == 4) req = '0;
    end
    @(posedge clk);
    #1;
    check("rr_idle", 32'({busy, gnt}), 32'd0);

    // Valid still high from the previous op on entering WAIT: only a fresh edge completes.
    @(negedge clk);
    m_lat = 6; m_keep = 1'b1; m_never = 1'b0; m_drop_at = 3;
    drive_req(0, 8'h11, 8'h22, 8'h5E, 1'b1);
    issue_check(0);
    req = '0;
    wait_done(k);
    check("held_valid_latency", 32'(k), 32'd7);
    @(posedge clk);
    m_keep = 1'b0; m_drop_at = -1;

    // Requester 2 drops req and changes its operands while in WAIT.
    @(negedge clk);
    m_lat = 4;
    drive_req(2, 8'h5A, 8'h11, 8'h6B, 1'b1);
    issue_check(2);
    @(posedge clk);
    #1;
    req = '0;
    op_a[23:16] = 8'hFF;
    op_b[23:16] = 8'hEE;
    @(posedge clk);
    #1;
    check("hold_adder_a", 32'(adder_a), 32'h5A);
    check("hold_adder_b", 32'(adder_b), 32'h11);
    wait_done(k);
    check("drop_req_latency", 32'(k), 32'd3);
    @(posedge clk);

    // Reset while waiting abandons the transaction silently.
    @(negedge clk);
    m_lat = 10;
    drive_req(3, 8'h01, 8'h02, 8'h03, 1'b0);
    issue_check(3);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("in_wait", 32'(dbg_state), 32'(ST_WAIT));
    k = n_done;
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrst_outputs", 32'({gnt, done, result, adder_a, adder_b, adder_start, busy}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(n_done), 32'(k));

`ifdef FP_ADD_SCHED_WATCHDOG_EN
    // Adder never answers: abort after TIMEOUT WAIT cycles, then serve the next requester.
    do_reset();
    @(negedge clk);
    m_never = 1'b1;
    drive_req(1, 8'h44, 8'h55, 8'h99, 1'b0);
    exp_q.push_back({4'b0010, 8'h00});
    issue_check(1);
    req = '0;
    wait_done(k);
    check("wd_latency", 32'(k), 32'(TB_TIMEOUT + 1));
    check("wd_err", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    check("wd_err_pulse", 32'({err, busy, gnt}), 32'd0);
    @(negedge clk);
    m_never = 1'b0; m_lat = 2;
    op_a = $urandom;
    op_b = $urandom;
    req = 4'b0110;
    ret_q.push_back(8'h3C);
    op_q.push_back({op_a[23:16], op_b[23:16]});
    exp_q.push_back({4'b0100, 8'h3C});
    issue_check(2);
    req = '0;
    wait_done(k);
    check("wd_next_latency", 32'(k), 32'd3);
    check("wd_next_err", 32'(err), 32'd0);
    @(posedge clk);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("opq_empty", 32'(op_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
